// File: rtl/adder32_slice_seq_if.sv
// Operand/result handshake bundle for adder32_slice_seq.
// master: the producer/consumer side (bench or upstream logic).
// slave:  the adder itself.
interface adder32_slice_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/adder32_slice_seq.sv
// Sequential slice-serial adder: adds SLICE_W bits per cycle over NSL cycles.
// Optional macro ADDER32_SLICE_SEQ_APPROX_EN: slice 0 becomes a^b with no carry into slice 1.
module adder32_slice_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 3
) (
  input logic                clk,
  input logic                rst,
  adder32_slice_seq_if.slave bus
);

  localparam int unsigned NSL      = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int unsigned PW       = NSL * SLICE_W;
  // Number of real operand bits in the top slice; its carry out of bit WIDTH-1
  // sits at this position of the widened slice sum.
  localparam int unsigned TOP_BITS = WIDTH - (NSL - 1) * SLICE_W;
  localparam int unsigned IDX_W    = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [PW-1:0]    a_q;
  logic [PW-1:0]    b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             cout_q;

  int unsigned      lo;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W:0]   sl_full;
  logic [WIDTH-1:0]   sum_upd;

  // Current slice add and the merged sum with that slice replaced.
  always_comb begin
    lo      = 32'(idx_q) * SLICE_W;
    a_sl    = SLICE_W'(a_q >> lo);
    b_sl    = SLICE_W'(b_q >> lo);
    sl_full = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
`ifdef ADDER32_SLICE_SEQ_APPROX_EN
    if (idx_q == '0) begin
      sl_full = {1'b0, a_sl ^ b_sl};
    end
`endif
    sum_upd = (sum_q & ~(SLICE_MASK << lo)) | (WIDTH'(sl_full[SLICE_W-1:0]) << lo);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            // Zero-extended so the top slice sees zeros above WIDTH-1.
            a_q     <= PW'(bus.a);
            b_q     <= PW'(bus.b);
            idx_q   <= '0;
            carry_q <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_upd;
          carry_q <= sl_full[SLICE_W];
          if (idx_q == LAST_IDX) begin
            cout_q  <= sl_full[TOP_BITS];
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_adder32_slice_seq.sv
// Self-checking bench for adder32_slice_seq (scoreboard of expected {cout,sum}).
module tb_adder32_slice_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSL   = 11;

  logic clk = 1'b0;
  logic rst;

  adder32_slice_seq_if #(.WIDTH(WIDTH)) bus ();

  adder32_slice_seq #(.WIDTH(WIDTH), .SLICE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [32:0] exp_q[$];

  // Reference result as {cout, sum}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef ADDER32_SLICE_SEQ_APPROX_EN
    logic [29:0] hi;
    hi = {1'b0, x[31:3]} + {1'b0, y[31:3]};
    return {hi, x[2:0] ^ y[2:0]};
`else
    return {1'b0, x} + {1'b0, y};
`endif
  endfunction

  task step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    exp_q.push_back(model(x, y));
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_state: busy=%b in_ready=%b required busy=1 in_ready=0",
               bus.busy, bus.in_ready);
    end
  endtask

  task automatic collect(input string name, output int lat, output logic [32:0] got);
    logic [32:0] exp;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, bus.out_valid);
    end
    got = {bus.cout, bus.sum};
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: result %h with no expectation queued", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_result: got cout,sum=%h required %h", name, got, exp);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_handoff: in_ready=%b out_valid=%b required 1,0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;  // reset must win over an offered pair
    bus.out_ready = 1'b0;
    bus.a         = 32'h1;
    bus.b         = 32'h2;
    step();
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b required 1,0,0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
    vectors++;
    if (bus.sum !== 32'h0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h cout=%b required 0,0", bus.sum, bus.cout);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    step();
  endtask

  task automatic test_directed();
    int lat;
    logic [32:0] got;
    accept(32'hFFFF_FFFF, 32'h0000_0001);
    collect("carry_all", lat, got);
`ifndef ADDER32_SLICE_SEQ_APPROX_EN
    vectors++;
    if (got !== 33'h1_0000_0000) begin
      errors++;
      $display("FAIL carry_all_const: got %h required 100000000", got);
    end
`endif
    accept(32'h1234_5678, 32'h1111_1111);
    collect("basic", lat, got);
    vectors++;
    if (lat != NSL) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required %0d", lat, NSL);
    end
`ifndef ADDER32_SLICE_SEQ_APPROX_EN
    vectors++;
    if (got !== 33'h0_2345_6789) begin
      errors++;
      $display("FAIL basic_const: got %h required 023456789", got);
    end
`endif
  endtask

  task automatic test_macro();
    int lat;
    logic [32:0] got;
    logic [32:0] want;
`ifdef ADDER32_SLICE_SEQ_APPROX_EN
    want = 33'h0_0000_0006;
`else
    want = 33'h0_0000_0008;
`endif
    accept(32'h0000_0007, 32'h0000_0001);
    collect("macro", lat, got);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL macro_const: got %h required %h", got, want);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int n = 0;
    logic [32:0] got;
    logic [31:0] held_sum;
    logic        held_cout;
    accept(32'hA5A5_A5A5, 32'h5A5A_5A5A);
    while (bus.out_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    held_sum  = bus.sum;
    held_cout = bus.cout;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sum !== held_sum || bus.cout !== held_cout) begin
        errors++;
        $display("FAIL backpressure_hold: out_valid=%b sum=%h cout=%b required 1,%h,%b",
                 bus.out_valid, bus.sum, bus.cout, held_sum, held_cout);
      end
    end
    collect("backpressure", lat, got);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [32:0] got;
    logic [32:0] dropped;
    accept(32'hDEAD_BEEF, 32'h0000_0001);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dropped = exp_q.pop_back();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.sum !== 32'h0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b sum=%h cout=%b required 0,0,1,0,0",
               bus.out_valid, bus.busy, bus.in_ready, bus.sum, bus.cout);
    end
    accept(32'h0000_0003, 32'h0000_0004);
    collect("after_reset", lat, got);
    vectors++;
    if (got !== 33'h0_0000_0007) begin
      errors++;
      $display("FAIL after_reset_const: got %h required 7 (dropped %h)", got, dropped);
    end
  endtask

  task automatic test_corruption();
    int lat;
    logic [32:0] got;
    for (int t = 0; t < 3; t++) begin
      accept($urandom, $urandom);
      for (int i = 0; i < 10; i++) begin
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.in_valid = 1'(($urandom_range(0, 1)));
        step();
      end
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      collect("corruption", lat, got);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [32:0] got;
    logic [31:0] xs[8];
    logic [31:0] ys[8];
    xs = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 0};
    ys = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) begin
      accept(xs[i], ys[i]);
      collect("b2b", lat, got);
      vectors++;
      if (lat != NSL) begin
        errors++;
        $display("FAIL b2b_latency: got %0d cycles required %0d", lat, NSL);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    test_reset();
    test_directed();
    test_macro();
    test_backpressure();
    test_reset_mid();
    test_corruption();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
